// File: rtl/vga_ov_pkg.sv
// vga_ov_pkg: frame-writer state encoding and video geometry defaults shared
// with the VGA scan-out and median filter blocks.
package vga_ov_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } fb_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ADDR_W_DEF   = 19;
    localparam int DATA_W_DEF   = 12;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_pos_counter.sv
// fb_pos_counter: x/y/linear-address position of the next pixel in a frame.
// A clear takes effect combinationally, so a pixel arriving with it lands at 0.
module fb_pos_counter
    import vga_ov_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int XW       = cnt_w(H_ACTIVE),
    parameter int YW       = cnt_w(V_ACTIVE)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              eol;

    always_comb begin
        x    = clr ? '0 : x_q;
        y    = clr ? '0 : y_q;
        addr = clr ? '0 : addr_q;
        eol  = x == XW'(H_ACTIVE - 1);
        last = eol && (y == YW'(V_ACTIVE - 1));
    end

    // After the last pixel everything wraps to 0 so the address stays in range.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (inc) begin
            x_q    <= eol ? '0 : x + XW'(1);
            y_q    <= last ? '0 : (eol ? y + YW'(1) : y);
            addr_q <= last ? '0 : addr + ADDR_W'(1);
        end else if (clr) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end
    end

endmodule

// File: rtl/filt_fb_writer.sv
// filt_fb_writer: writes the filtered pixel stream into the frame buffer and
// flags short/long frames. Define FB_WR_BORDER_EN to blank the frame border.
module filt_fb_writer
    import vga_ov_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              sof,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err_short,
    output logic              err_long
);

    localparam int XW = cnt_w(H_ACTIVE);
    localparam int YW = cnt_w(V_ACTIVE);

`ifdef FB_WR_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    fb_state_t         state, state_next;
    logic              accept, drop, restart, last, on_border;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_next;

    fb_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W),
        .XW       (XW),
        .YW       (YW)
    ) u_pos (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (sof),
        .inc    (accept),
        .x      (x),
        .y      (y),
        .addr   (addr),
        .last   (last)
    );

    // sof wins over pix_valid: it reopens the frame and the pixel goes to address 0.
    always_comb begin
        state_next = state;
        restart    = sof && (state == ACTIVE);
        accept     = pix_valid && (sof || state == ACTIVE);
        drop       = pix_valid && !sof && (state == DONE);
        if (sof)
            state_next = ACTIVE;
        if (accept && last)
            state_next = DONE;
        on_border  = (x == '0) || (x == XW'(H_ACTIVE - 1)) ||
                     (y == '0) || (y == YW'(V_ACTIVE - 1));
        data_next  = (BORDER_EN && on_border) ? '0 : pix_in;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            wr_en      <= accept;
            frame_done <= accept && last;
            err_short  <= err_short || restart;
            err_long   <= err_long || drop;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= data_next;
            end
        end
    end

    assign busy = state == ACTIVE;

endmodule

// File: doc/filt_fb_writer.md
# filt_fb_writer

Consumer end of the filtered-pixel stream: takes the 12-bit RGB444 pixels emitted by the 3x3 median filter stage, one per `pix_valid` strobe, and writes them into the dual-port frame buffer that the VGA scan-out side reads. It tracks frame position with column/row counters and generates a linear write address. It flags frames that are short (restarted early) or long (excess pixels) so display glitches can be traced to the capture side.

## Interface
- `H_ACTIVE`, 640, pixels per line.
- `V_ACTIVE`, 480, lines per frame.
- `ADDR_W`, 19, frame buffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE.
- `DATA_W`, 12, pixel width (RGB444).
- `clk_in`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sof`  in  1  start-of-frame pulse, one cycle, precedes the first pixel of a frame.
- `pix_in`  in  DATA_W  filtered pixel.
- `pix_valid`  in  1  `pix_in` valid this cycle.
- `wr_en`  out  1  frame buffer write strobe.
- `wr_addr`  out  ADDR_W  frame buffer write address.
- `wr_data`  out  DATA_W  frame buffer write data.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a complete frame is written.
- `busy`  out  1  high while in ACTIVE.
- `err_short`  out  1  sticky; `sof` arrived before the frame completed.
- `err_long`  out  1  sticky; `pix_valid` arrived in DONE before the next `sof`.

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - Ignores `pix_valid`.
  - `sof` → ACTIVE, clears x/y/address counters.
- ACTIVE, each `pix_valid`:
  - Write the pixel at the current address, then increment x and the address.
  - At x == H_ACTIVE-1: x wraps to 0 and y increments.
  - At x == H_ACTIVE-1 and y == V_ACTIVE-1: → DONE and pulse `frame_done`.
- DONE:
  - `sof` → ACTIVE with counters cleared.
  - `pix_valid` is dropped (no write) and sets `err_long`.
- `sof` in ACTIVE:
  - Sets `err_short`.
  - Clears counters and stays in ACTIVE; the new frame overwrites from address 0.
- `sof` and `pix_valid` in the same cycle: `sof` wins. Counters clear first, and that pixel is written to address 0 as the first pixel of the new frame.
- Address is kept as a running counter (no multiplier). It equals y*H_ACTIVE + x and never exceeds H_ACTIVE*V_ACTIVE-1.
- `err_short` and `err_long` clear only on reset.
- Reset mid-frame: all state is lost and the block returns to IDLE. The next frame begins at the next `sof`.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `busy`=0, `err_short`=0, `err_long`=0; state IDLE.
- Latency is one cycle: a `pix_valid` at edge N produces `wr_en`/`wr_addr`/`wr_data` registered and valid after edge N+1.
- `wr_en` is high only for one cycle per accepted pixel; back-to-back `pix_valid` gives back-to-back writes.
- `frame_done` is asserted in the same cycle as the final write's `wr_en`.
- `busy` is asserted the cycle after `sof` is sampled and deasserted the cycle `frame_done` is asserted.
- There is no backpressure; the frame buffer port accepts one write per cycle.

## Configuration
- `FB_WR_BORDER_EN` defined:
  - Pixels at x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 are written as 0. This blanks the invalid edge outputs of the 3x3 window.
  - Address sequencing is unchanged.
- Undefined: every pixel is written as received.

## Structure
- Shared package `vga_ov_pkg` holds:
  - the state enum (IDLE/ACTIVE/DONE);
  - defaults for H_ACTIVE, V_ACTIVE, ADDR_W and DATA_W, shared with the VGA scan-out and median filter blocks.
- One sub-module is natural: `fb_pos_counter`, holding the x/y/address counters with clear, increment and last-pixel flag. The FSM and the border mux stay in the top.

## Test plan
- Full frame, H_ACTIVE=4, V_ACTIVE=3, continuous `pix_valid` with pix_in = 0x000..0x00B after `sof` → 12 writes at addr 0..11 with matching data. `frame_done` pulses with the addr-11 write.
- Same frame with `pix_valid` toggling every other cycle → same 12 writes, gaps preserved, data/address unchanged.
- `sof` after 5 pixels, then a full frame → `err_short`=1; writes restart at addr 0; `frame_done` fires once, at the end of the second frame.
- 14 pixels after one `sof` → 12 writes, `frame_done` once, no writes for pixels 13–14, `err_long`=1.
- Assert `rst` low at pixel 7, release, send `sof` plus a full frame → all outputs 0 during reset; writes restart at addr 0; no error flags.
- With `FB_WR_BORDER_EN`, 4x3 frame of 0xFFF → only addr 5 and 6 carry 0xFFF; all other addresses are written 0x000.
